dmem_access_ctrl: RTL and testbench

- Sequences every load/store from the memory stage onto the multi-cycle, stalling data memory (stallmem-style interface: Rd/Wr/Addr/DataIn in; DataOut/Done/Stall/CacheHit/err out).
- Issues the access and freezes the pipeline until the memory reports Done.
- Captures read data, escalates misalignment/timeout as a sticky fault, and sequences the halt-time dump.
- Keeps hit/miss statistics.

---
 rtl/dmem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: issues loads/stores to a stalling memory, freezes the
// pipeline until done, captures load data, tracks hit/miss counts and sticky faults.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    input  logic             halt,
    input  logic             mem_stall,
    input  logic             mem_done,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_err,
    input  logic             mem_hit,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_dump,
    output logic             pipe_stall,
    output logic [15:0]      rdata,
    output logic             rdata_valid,
    output logic             fault,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDump,
        StHalted,
        StFault
    } state_e;

    state_e           r_state;
    logic             r_is_rd;
    logic [TW-1:0]    r_tmo;
    logic [15:0]      r_addr;
    logic [15:0]      r_wdata;
    logic [15:0]      r_rdata;
    logic [CNT_W-1:0] r_hit;
    logic [CNT_W-1:0] r_miss;
    logic             w_req;
    logic             w_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_is_rd <= 1'b0;
            r_tmo   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hit   <= '0;
            r_miss  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_rd && req_wr) begin
                        r_state <= StFault;
                    end else if (req_rd || req_wr) begin
                        if (!mem_stall) begin
                            r_addr  <= req_addr;
                            r_wdata <= req_wdata;
                            r_is_rd <= req_rd;
                            r_state <= StIssue;
                        end
                    end else if (halt) begin
                        r_state <= StDump;
                    end
                end
                StIssue: begin
                    r_tmo   <= '0;
                    r_state <= mem_err ? StFault : StWait;
                end
                StWait: begin
                    // A completion in the last permitted cycle beats the timeout.
                    if (mem_done) begin
                        if (r_is_rd) begin
                            r_rdata <= mem_rdata;
                        end
                        if (mem_hit) begin
                            if (r_hit != {CNT_W{1'b1}}) r_hit <= r_hit + 1'b1;
                        end else begin
                            if (r_miss != {CNT_W{1'b1}}) r_miss <= r_miss + 1'b1;
                        end
                        r_state <= mem_err ? StFault : StResp;
                    end else if (r_tmo == TmoLast) begin
                        r_state <= StFault;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                StResp:   r_state <= StIdle;
                StDump:   r_state <= StHalted;
                StHalted: r_state <= StHalted;
                StFault:  r_state <= StFault;
                default:  r_state <= StFault;
            endcase
        end
    end

    assign w_req  = req_rd || req_wr;
    assign w_busy = (r_state == StIssue) || (r_state == StWait) || (r_state == StDump) ||
                    (r_state == StHalted) || (r_state == StFault);

    // Gated by reset so a request held across reset cannot leak a stall.
    assign pipe_stall  = rst && (w_busy || ((r_state == StIdle) && w_req));
    assign mem_rd      = (r_state == StIssue) && r_is_rd;
    assign mem_wr      = (r_state == StIssue) && !r_is_rd;
    assign mem_dump    = (r_state == StDump);
    assign fault       = (r_state == StFault);
    assign rdata_valid = (r_state == StResp) && r_is_rd;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign rdata       = r_rdata;
    assign hit_cnt     = r_hit;
    assign miss_cnt    = r_miss;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized back-to-back
// accesses checked against a cycle-schedule model derived from the access protocol.
module tb_dmem_access_ctrl;

    localparam int unsigned CW  = 4;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_rd = 1'b0, req_wr = 1'b0, halt = 1'b0;
    logic [15:0]   req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic          mem_stall = 1'b0, mem_done = 1'b0, mem_err = 1'b0, mem_hit = 1'b0;
    logic          mem_rd, mem_wr, mem_dump, pipe_stall, rdata_valid, fault;
    logic [15:0]   mem_addr, mem_wdata, rdata;
    logic [CW-1:0] hit_cnt, miss_cnt;

    int checks   = 0;
    int failures = 0;

    logic [CW-1:0] exp_hit  = '0;
    logic [CW-1:0] exp_miss = '0;
    logic [15:0]   exp_rdata = '0;

    dmem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .halt(halt), .mem_stall(mem_stall), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .mem_hit(mem_hit), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dump(mem_dump),
        .pipe_stall(pipe_stall), .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req_rd = 0; req_wr = 0; halt = 0; mem_stall = 0; mem_done = 0; mem_err = 0;
        mem_hit = 0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        exp_hit = '0; exp_miss = '0; exp_rdata = '0;
    endtask

    // One access: stall_cyc IDLE cycles of back-pressure, completion lat cycles after ISSUE.
    task automatic run_access(input bit rd, input logic [15:0] addr, input logic [15:0] wdata,
                              input int stall_cyc, input int lat, input bit hit,
                              input logic [15:0] rdat, input bit spurious);
        int issue = stall_cyc + 1;
        int done_c = issue + lat;
        int resp = done_c + 1;
        for (int c = 0; c <= resp; c++) begin
            req_rd = rd; req_wr = !rd; req_addr = addr; req_wdata = wdata;
            mem_stall = (c < stall_cyc);
            mem_done  = (c == done_c) || (spurious && c < issue && $urandom_range(1) == 1);
            mem_hit   = hit;
            mem_rdata = (c == done_c) ? rdat : 16'($urandom);
            if (c == resp) begin
                if (rd) exp_rdata = rdat;
                if (hit) begin
                    if (exp_hit != '1) exp_hit = exp_hit + 1'b1;
                end else begin
                    if (exp_miss != '1) exp_miss = exp_miss + 1'b1;
                end
            end
            @(negedge clk);
            checks++;
            if (pipe_stall !== (c < resp)) begin
                failures++;
                $display("FAIL access_pipe_stall c=%0d got=%b exp=%b", c, pipe_stall, c < resp);
            end
            checks++;
            if (mem_rd !== (rd && c == issue) || mem_wr !== (!rd && c == issue)) begin
                failures++;
                $display("FAIL access_strobe c=%0d got rd=%b wr=%b exp rd=%b wr=%b", c,
                         mem_rd, mem_wr, rd && c == issue, !rd && c == issue);
            end
            checks++;
            if (rdata_valid !== (rd && c == resp)) begin
                failures++;
                $display("FAIL access_rdata_valid c=%0d got=%b exp=%b", c, rdata_valid,
                         rd && c == resp);
            end
            if (c == issue) begin
                checks++;
                if (mem_addr !== addr || mem_wdata !== wdata) begin
                    failures++;
                    $display("FAIL access_addr_wdata got=%h/%h exp=%h/%h", mem_addr,
                             mem_wdata, addr, wdata);
                end
            end
            if (c == resp) begin
                checks++;
                if (rdata !== exp_rdata) begin
                    failures++;
                    $display("FAIL access_rdata got=%h exp=%h", rdata, exp_rdata);
                end
                checks++;
                if (hit_cnt !== exp_hit || miss_cnt !== exp_miss || fault !== 1'b0) begin
                    failures++;
                    $display("FAIL access_counters got hit=%0d miss=%0d fault=%b exp %0d %0d 0",
                             hit_cnt, miss_cnt, fault, exp_hit, exp_miss);
                end
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #3;
        checks++;
        if ({mem_rd, mem_wr, mem_dump, pipe_stall, rdata_valid, fault} !== 6'b0 ||
            mem_addr !== 16'h0 || mem_wdata !== 16'h0 || rdata !== 16'h0 ||
            hit_cnt !== '0 || miss_cnt !== '0) begin
            failures++;
            $display("FAIL reset_outputs got flags=%b addr=%h wdata=%h rdata=%h hit=%0d miss=%0d exp all 0",
                     {mem_rd, mem_wr, mem_dump, pipe_stall, rdata_valid, fault},
                     mem_addr, mem_wdata, rdata, hit_cnt, miss_cnt);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (pipe_stall !== 1'b0 || fault !== 1'b0 || mem_dump !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got stall=%b fault=%b dump=%b exp 0 0 0",
                     pipe_stall, fault, mem_dump);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_hit();
        run_access(1'b1, 16'h0010, 16'h0000, 0, 1, 1'b1, 16'hBEEF, 1'b0);
    endtask

    task automatic test_store_miss();
        run_access(1'b0, 16'h0020, 16'h1234, 0, 5, 1'b0, 16'h5555, 1'b0);
    endtask

    task automatic test_backpressure();
        run_access(1'b1, 16'h0040, 16'h0000, 3, 2, 1'b1, 16'hCAFE, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            run_access(1'($urandom_range(1)), 16'($urandom), 16'($urandom),
                       $urandom_range(0, 3), $urandom_range(1, 8),
                       $urandom_range(3) != 0, 16'($urandom), 1'b1);
        end
    endtask

    task automatic test_reset_mid_access();
        req_rd = 1; req_addr = 16'h0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 0;
        #1;
        checks++;
        if ({mem_rd, mem_wr, pipe_stall, rdata_valid, fault} !== 5'b0 ||
            hit_cnt !== '0 || miss_cnt !== '0 || rdata !== 16'h0 || mem_addr !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_access got flags=%b hit=%0d miss=%0d rdata=%h addr=%h exp 0",
                     {mem_rd, mem_wr, pipe_stall, rdata_valid, fault}, hit_cnt, miss_cnt,
                     rdata, mem_addr);
        end
        idle_inputs();
        exp_hit = '0; exp_miss = '0; exp_rdata = '0;
        @(posedge clk); #1 rst = 1;
        mem_done = 1; mem_hit = 1; mem_rdata = 16'hAAAA;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (hit_cnt !== '0 || rdata !== 16'h0 || pipe_stall !== 1'b0) begin
            failures++;
            $display("FAIL late_done_ignored got hit=%0d rdata=%h stall=%b exp 0 0000 0",
                     hit_cnt, rdata, pipe_stall);
        end
        @(posedge clk); #1;
        run_access(1'b1, 16'h0090, 16'h0000, 0, 2, 1'b1, 16'h1357, 1'b0);
    endtask

    task automatic test_unaligned_fault();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            req_rd = 1; req_addr = 16'h0011;
            mem_err = (c == 1);
            halt = (c >= 3);
            mem_done = (c >= 3);
            @(negedge clk);
            checks++;
            if (fault !== (c >= 2) || pipe_stall !== 1'b1 || mem_rd !== (c == 1) ||
                mem_dump !== 1'b0) begin
                failures++;
                $display("FAIL unaligned_fault c=%0d got fault=%b stall=%b rd=%b dump=%b exp %b 1 %b 0",
                         c, fault, pipe_stall, mem_rd, mem_dump, c >= 2, c == 1);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int c = 0; c < 69; c++) begin
            req_wr = 1; req_addr = 16'h0030;
            @(negedge clk);
            checks++;
            if (fault !== (c >= TMO + 2) || pipe_stall !== 1'b1) begin
                failures++;
                $display("FAIL timeout c=%0d got fault=%b stall=%b exp %b 1", c, fault,
                         pipe_stall, c >= TMO + 2);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_both_req();
        apply_reset();
        req_rd = 1; req_wr = 1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL both_req_fault got fault=%b rd=%b wr=%b exp 1 0 0", fault, mem_rd,
                     mem_wr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_halt();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            halt = (c == 0) || ($urandom_range(1) == 1);
            req_rd = (c >= 2);
            mem_done = (c >= 2);
            @(negedge clk);
            checks++;
            if (mem_dump !== (c == 1) || pipe_stall !== (c >= 1) || mem_rd !== 1'b0 ||
                fault !== 1'b0) begin
                failures++;
                $display("FAIL halt c=%0d got dump=%b stall=%b rd=%b fault=%b exp %b %b 0 0",
                         c, mem_dump, pipe_stall, mem_rd, fault, c == 1, c >= 1);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_hit();
        test_store_miss();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();
        test_unaligned_fault();
        test_timeout();
        test_both_req();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
